// File: rtl/kalman_filter_1d.sv
// kalman_filter_1d: scalar Kalman filter, one 20-cycle update per accepted measurement.
// Define KALMAN_OVERRUN_CNT_EN to add the overrun_cnt output (dropped meas_valid count).
module kalman_filter_1d #(
  parameter logic [15:0] P_INIT = 16'h1000,
  parameter logic [15:0] Q      = 16'h0010,
  parameter logic [15:0] R      = 16'h0100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] meas_data,
  input  logic        meas_valid,
  output logic [15:0] filtered_data,
  output logic        filter_done,
  output logic        busy
`ifdef KALMAN_OVERRUN_CNT_EN
  ,
  output logic [7:0]  overrun_cnt
`endif
);
  if (R == 16'd0) begin : g_r_zero
    $error("kalman_filter_1d: R must be nonzero");
  end
  typedef enum logic [2:0] {IDLE, PREDICT, DIVIDE, UPDATE, DONE} state_t;
  state_t state;
  logic go, first;
  logic [15:0] z, x, p, p_pred, k;
  logic [16:0] den, rem, p_sum, rem_nx;
  logic [17:0] rem_sh;
  logic [3:0] cnt;
  logic [15:0] p_sat, x_upd, x_new, p_new;
  logic ge;
  logic signed [16:0] innov;
  logic signed [33:0] prod, dx;
  logic [31:0] kp;
  assign p_sum  = {1'b0, p} + {1'b0, Q};
  assign p_sat  = p_sum[16] ? 16'hFFFF : p_sum[15:0];
  // remainder stays below den, so one extra bit covers the shifted value
  assign rem_sh = {rem, 1'b0};
  assign ge     = rem_sh >= {1'b0, den};
  assign rem_nx = ge ? 17'(rem_sh - {1'b0, den}) : rem_sh[16:0];
  assign innov  = $signed({1'b0, z}) - $signed({1'b0, x});
  assign prod   = $signed({1'b0, k}) * innov;
  assign dx     = (prod >>> 16) + $signed({18'b0, x});
  assign x_upd  = dx < 0 ? 16'h0000 : dx > 34'sd65535 ? 16'hFFFF : dx[15:0];
  assign kp     = k * p_pred;
  assign x_new  = first ? z : x_upd;
  assign p_new  = first ? P_INIT : p_pred - 16'(kp >> 16);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      go            <= 1'b0;
      first         <= 1'b1;
      z             <= '0;
      x             <= '0;
      p             <= P_INIT;
      p_pred        <= '0;
      k             <= '0;
      den           <= '0;
      rem           <= '0;
      cnt           <= '0;
      filtered_data <= '0;
      filter_done   <= 1'b0;
      busy          <= 1'b0;
    end else begin
      filter_done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          state <= go ? PREDICT : IDLE;
          go    <= !go && meas_valid;
          busy  <= go || meas_valid;
          if (!go && meas_valid) z <= meas_data;
        end
        PREDICT: begin
          p_pred <= p_sat;
          den    <= {1'b0, p_sat} + {1'b0, R};
          rem    <= {1'b0, p_sat};
          cnt    <= '0;
          state  <= DIVIDE;
        end
        DIVIDE: begin
          rem   <= rem_nx;
          k     <= {k[14:0], ge};
          cnt   <= cnt + 4'd1;
          state <= cnt == 4'd15 ? UPDATE : DIVIDE;
        end
        UPDATE: begin
          x             <= x_new;
          p             <= p_new;
          first         <= 1'b0;
          filtered_data <= x_new;
          filter_done   <= 1'b1;
          busy          <= 1'b0;
          state         <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end
`ifdef KALMAN_OVERRUN_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) overrun_cnt <= '0;
    else if (meas_valid && busy && overrun_cnt != 8'hFF) overrun_cnt <= overrun_cnt + 8'd1;
  end
`endif
endmodule

// File: tb/tb_kalman_filter_1d.sv
// tb_kalman_filter_1d: directed vectors for kalman_filter_1d (default and saturating P_INIT instances).
module tb_kalman_filter_1d;
  logic clk = 1'b0, rst_n = 1'b0, mv1 = 1'b0, mv2 = 1'b0;
  logic [15:0] meas = '0;
  logic [15:0] fd1, fd2;
  logic done1, done2, busy1, busy2;
`ifdef KALMAN_OVERRUN_CNT_EN
  logic [7:0] ov1, ov2;
`endif
  int errors = 0, checks = 0;

  kalman_filter_1d dut1 (
    .clk(clk), .rst_n(rst_n), .meas_data(meas), .meas_valid(mv1),
    .filtered_data(fd1), .filter_done(done1), .busy(busy1)
`ifdef KALMAN_OVERRUN_CNT_EN
    , .overrun_cnt(ov1)
`endif
  );
  kalman_filter_1d #(.P_INIT(16'hFFFF), .Q(16'h0010), .R(16'h0100)) dut2 (
    .clk(clk), .rst_n(rst_n), .meas_data(meas), .meas_valid(mv2),
    .filtered_data(fd2), .filter_done(done2), .busy(busy2)
`ifdef KALMAN_OVERRUN_CNT_EN
    , .overrun_cnt(ov2)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, got, got, exp, exp);
    end
  endtask

  // lat counts edges after the capture edge until filter_done is seen; -1 on timeout
  task automatic sample(input bit sel, input bit now, input logic [15:0] zv,
                        output int lat, output logic [15:0] xv, output logic b1);
    if (!now) @(negedge clk);
    meas = zv;
    if (sel) mv2 = 1'b1; else mv1 = 1'b1;
    @(posedge clk);
    #1 mv1 = 1'b0; mv2 = 1'b0;
    lat = -1; xv = '0; b1 = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (i == 1) b1 = sel ? busy2 : busy1;
      if (sel ? done2 : done1) begin
        lat = i;
        xv = sel ? fd2 : fd1;
        break;
      end
    end
  endtask

  typedef struct {
    bit          sel;
    logic [15:0] z;
    logic [15:0] x;
  } vec_t;
  vec_t v[3];

  initial begin
    int lat, n;
    logic [15:0] xv;
    logic b1;
    v[0] = '{1'b0, 16'h1234, 16'h1234};
    v[1] = '{1'b0, 16'h2234, 16'h2143};
    v[2] = '{1'b0, 16'h0000, 16'h1090};
    repeat (3) @(negedge clk);
    check("reset_filtered_data", fd1, 0);
    check("reset_filter_done", done1, 0);
    check("reset_busy", busy1, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sample(v[i].sel, 1'b0, v[i].z, lat, xv, b1);
      check($sformatf("vec%0d_latency", i), lat, 19);
      check($sformatf("vec%0d_x", i), xv, v[i].x);
      check($sformatf("vec%0d_busy", i), b1, 1);
    end
    @(negedge clk);
    meas = 16'h1090; mv1 = 1'b1;
    @(posedge clk);
    #1 mv1 = 1'b0;
    repeat (2) @(negedge clk);
    meas = 16'hFFFF; mv1 = 1'b1;
    repeat (5) @(negedge clk);
    mv1 = 1'b0;
    n = 0; xv = '0;
    repeat (30) begin
      @(negedge clk);
      if (done1) begin n++; xv = fd1; end
    end
    check("overrun_done_count", n, 1);
    check("overrun_x", xv, 16'h1090);
`ifdef KALMAN_OVERRUN_CNT_EN
    check("overrun_cnt", ov1, 5);
`endif
    sample(1'b0, 1'b0, 16'h1090, lat, xv, b1);
    check("pre_done_latency", lat, 19);
    sample(1'b0, 1'b1, 16'h1090, lat, xv, b1);
    check("done_cycle_gap", lat + 1, 20);
    check("done_cycle_x", xv, 16'h1090);
    @(negedge clk);
    check("done_single_pulse", done1, 0);
    @(negedge clk);
    meas = 16'h5555; mv1 = 1'b1;
    @(posedge clk);
    #1 mv1 = 1'b0;
    repeat (9) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_filtered_data", fd1, 0);
    check("abort_filter_done", done1, 0);
    check("abort_busy", busy1, 0);
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    repeat (30) begin
      @(negedge clk);
      if (done1) n++;
    end
    check("abort_no_done", n, 0);
    check("abort_hold_zero", fd1, 0);
`ifdef KALMAN_OVERRUN_CNT_EN
    check("abort_overrun_reset", ov1, 0);
`endif
    sample(1'b0, 1'b0, 16'h00AA, lat, xv, b1);
    check("post_abort_latency", lat, 19);
    check("post_abort_x", xv, 16'h00AA);
    sample(1'b1, 1'b0, 16'h1000, lat, xv, b1);
    check("sat_first_latency", lat, 19);
    check("sat_first_x", xv, 16'h1000);
    sample(1'b1, 1'b0, 16'h3000, lat, xv, b1);
    check("sat_second_latency", lat, 19);
    check("sat_second_x", xv, 16'h2FE0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/kalman_filter_1d.md
KALMAN_FILTER_1D -- requirements
Module: kalman_filter_1d

Interface
REQ-001 Parameters SHALL be, one per line as name, default, meaning:
- P_INIT, 16'h1000, error covariance loaded at reset and on the first sample.
- Q, 16'h0010, process noise.
- R, 16'h0100, measurement noise; R=0 SHALL cause an elaboration error.
REQ-002 Ports SHALL be, one per line as name, direction, width, meaning:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- meas_data  in  16  unsigned measurement z.
- meas_valid  in  1  z is valid this cycle.
- filtered_data  out  16  state estimate x, held between updates; feeds the SPI serializer.
- filter_done  out  1  one-cycle strobe: filtered_data is new.
- busy  out  1  update in progress; meas_valid is ignored while high.
REQ-003 One clock; reset is asynchronous and active-low; all state SHALL be clocked by clk.

Function
REQ-004 The FSM SHALL have states IDLE, PREDICT, DIVIDE, UPDATE, DONE.
REQ-005 In IDLE or DONE, meas_valid=1 SHALL capture meas_data, enter PREDICT next edge.
REQ-006 busy SHALL be 1 in PREDICT, DIVIDE, UPDATE; 0 in IDLE, DONE.
REQ-007 PREDICT, one cycle: P_pred = P + Q, unsigned, saturating at 16'hFFFF.
REQ-008 DIVIDE, exactly 16 cycles of restoring division: K = floor(P_pred*2^16 / (P_pred+R)).
- Denominator 17 bits; K is 16-bit unsigned Q0.16, always < 1.0.
REQ-009 UPDATE, one cycle:
- innovation = z - x, signed 17-bit.
- x = x + (K*innovation >>> 16), arithmetic floor shift.
- Result clamped to 0..16'hFFFF.
REQ-010 UPDATE SHALL set P = P_pred - floor(K*P_pred / 2^16).
REQ-011 DONE, one cycle: filter_done=1, filtered_data=x; then IDLE unless REQ-005 applies.
REQ-012 Latency: meas_valid sampled at edge N SHALL give filter_done=1 during the cycle after edge N+19, every sample.
REQ-013 First sample after reset: x=z and P=P_INIT, with the same timing as REQ-012 and no arithmetic applied.
REQ-014 meas_valid while busy=1 SHALL be dropped without affecting state.
REQ-015 filter_done SHALL never be high two consecutive cycles.
REQ-016 filtered_data SHALL change only on the edge that raises filter_done.

Reset
REQ-017 rst_n=0 SHALL immediately force the following, regardless of state (including mid-DIVIDE):
- state=IDLE.
- filtered_data=0, filter_done=0, busy=0.
- x=0, P=P_INIT, first-sample flag set.
REQ-018 An update aborted by reset SHALL never produce filter_done.

Configuration
REQ-019 With macro KALMAN_OVERRUN_CNT_EN defined: add output overrun_cnt [7:0].
- It counts meas_valid cycles dropped per REQ-014.
- It saturates at 8'hFF and resets to 0.
REQ-020 Without KALMAN_OVERRUN_CNT_EN: port and counter SHALL be absent; behaviour otherwise identical.

Verification
REQ-021 Reset, then meas 16'h1234 at edge N -> filter_done single pulse after edge N+19; filtered_data=16'h1234.
REQ-022 Second meas 16'h2234 with default parameters -> intermediate and final values:
- K=61695.
- filtered_data=16'h2143.
- internal P=242.
REQ-023 meas_valid held high for 5 cycles during busy -> no extra update; overrun_cnt=5 when the macro is defined.
REQ-024 rst_n pulsed low in the 8th DIVIDE cycle:
- No filter_done; outputs are 0.
- Next meas 16'h00AA -> filtered_data=16'h00AA (first-sample path).
REQ-025 meas_valid in the DONE cycle -> accepted; next filter_done exactly 20 cycles after the previous one.
REQ-026 P_INIT=16'hFFFF, Q=16'h0010 -> P_pred saturates at 16'hFFFF with no wrap; K and x match the reference model.
